// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock core: mode encoding, digit
// indices, active-low segment codes and the HH:MM digit arithmetic helpers.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    CLK_SET = 2'd1,
    ALM_SET = 2'd2
  } mode_e;

  localparam logic [1:0] MIN_U  = 2'd0;
  localparam logic [1:0] MIN_T  = 2'd1;
  localparam logic [1:0] HOUR_U = 2'd2;
  localparam logic [1:0] HOUR_T = 2'd3;

  // Segment codes are {g,f,e,d,c,b,a}, a lit segment is 0.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  typedef struct packed {
    logic [3:0] ht;
    logic [3:0] hu;
    logic [3:0] mt;
    logic [3:0] mu;
  } hhmm_t;

  // One-minute advance with full carry into the hours, 23:59 -> 00:00.
  function automatic hhmm_t next_minute(hhmm_t v);
    hhmm_t r;
    r = v;
    if (v.mu != 4'd9) begin
      r.mu = v.mu + 4'd1;
    end else begin
      r.mu = 4'd0;
      if (v.mt != 4'd5) begin
        r.mt = v.mt + 4'd1;
      end else begin
        r.mt = 4'd0;
        if (v.ht == 4'd2 && v.hu == 4'd3) begin
          r.ht = 4'd0;
          r.hu = 4'd0;
        end else if (v.hu == 4'd9) begin
          r.hu = 4'd0;
          r.ht = v.ht + 4'd1;
        end else begin
          r.hu = v.hu + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // User edit: bump one digit with its own wrap, never carrying into a neighbour.
  function automatic hhmm_t bump_digit(hhmm_t v, logic [1:0] idx);
    hhmm_t r;
    r = v;
    case (idx)
      MIN_U:  r.mu = (v.mu >= 4'd9) ? 4'd0 : v.mu + 4'd1;
      MIN_T:  r.mt = (v.mt >= 4'd5) ? 4'd0 : v.mt + 4'd1;
      HOUR_U: begin
        if (v.ht == 4'd2) r.hu = (v.hu >= 4'd3) ? 4'd0 : v.hu + 4'd1;
        else              r.hu = (v.hu >= 4'd9) ? 4'd0 : v.hu + 4'd1;
      end
      HOUR_T: begin
        r.ht = (v.ht >= 4'd2) ? 4'd0 : v.ht + 4'd1;
        if (r.ht == 4'd2 && v.hu > 4'd3) r.hu = 4'd3;
      end
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment code; non-decimal codes blank.
module bcd_to_seg7
  import alarm_clock_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/alarm_clock_core.sv
// 24 h clock with HH:MM alarm, RUN/CLK_SET/ALM_SET editing and registered display outputs.
// Optional snooze is built when ALARM_SNOOZE_EN is defined.
module alarm_clock_core
  import alarm_clock_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int RING_SECONDS = 60,
  parameter int SNOOZE_MIN   = 5
) (
  input  logic       MCLK,
  input  logic       RSTN,
  input  logic       BTN_MODE,
  input  logic       BTN_LEFT,
  input  logic       BTN_UP,
  input  logic       BTN_STOP,
  input  logic       ALARM_EN,
  output logic [6:0] DISPLAY_3,
  output logic [6:0] DISPLAY_2,
  output logic [6:0] DISPLAY_1,
  output logic [6:0] DISPLAY_0,
  output logic       clock_set,
  output logic       alarm_set,
  output logic       alarm_ringing,
  output logic [1:0] location,
  output logic [1:0] alarm_location
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam int RW = $clog2(RING_SECONDS + 1);

  if (CLK_HZ < 2 || RING_SECONDS < 1 || SNOOZE_MIN < 1) begin : g_param_check
    $error("alarm_clock_core: CLK_HZ >= 2, RING_SECONDS >= 1, SNOOZE_MIN >= 1 required");
  end

  logic [3:0]    btn_raw, btn_s1_q, btn_s2_q, btn_prev_q, btn_pulse;
  logic [1:0]    en_sync_q;
  logic          en_prev_q, alarm_en, en_fall;
  logic          mode_pulse, left_act, up_act, stop_pulse;
  mode_e         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  hhmm_t         time_q, time_d, alarm_q, alarm_d, next_min, disp_src;
  logic [1:0]    loc_q, loc_d, aloc_q, aloc_d;
  logic          ring_q, ring_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic          tick, min_roll, trigger, clock_set_d, alarm_set_d;
  logic [6:0]    seg3_d, seg2_d, seg1_d, seg0_d, seg3_q, seg2_q, seg1_q, seg0_q;
  logic          clock_set_q, alarm_set_q, ring_out_q;
  logic [1:0]    loc_out_q, aloc_out_q;

  // Flops preset to 1 so a button already held when reset lifts makes no edge.
  assign btn_raw = {BTN_STOP, BTN_UP, BTN_LEFT, BTN_MODE};
  always_ff @(posedge MCLK) begin
    if (!RSTN) begin
      btn_s1_q   <= 4'hF;
      btn_s2_q   <= 4'hF;
      btn_prev_q <= 4'hF;
      en_sync_q  <= 2'b00;
      en_prev_q  <= 1'b0;
    end else begin
      btn_s1_q   <= btn_raw;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
      en_sync_q  <= {en_sync_q[0], ALARM_EN};
      en_prev_q  <= en_sync_q[1];
    end
  end

  assign btn_pulse  = btn_s2_q & ~btn_prev_q;
  assign mode_pulse = btn_pulse[0];
  assign left_act   = btn_pulse[1] & ~btn_pulse[0];
  assign up_act     = btn_pulse[2] & ~|btn_pulse[1:0];
  assign stop_pulse = btn_pulse[3];
  assign alarm_en   = en_sync_q[1];
  assign en_fall    = en_prev_q & ~en_sync_q[1];

  always_ff @(posedge MCLK) begin
    if (!RSTN) mode_q <= RUN;
    else       mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_pulse) begin
      case (mode_q)
        RUN:     mode_d = CLK_SET;
        CLK_SET: mode_d = ALM_SET;
        default: mode_d = RUN;
      endcase
    end
  end

  always_comb begin
    clock_set_d = (mode_q == CLK_SET);
    alarm_set_d = (mode_q == ALM_SET);
    disp_src    = (mode_q == ALM_SET) ? alarm_q : time_q;
  end

  assign tick     = (mode_q != CLK_SET) && (presc_q == PW'(CLK_HZ - 1));
  assign min_roll = tick && (sec_q == 6'd59);
  assign next_min = next_minute(time_q);
  assign trigger  = min_roll && (mode_q == RUN) && alarm_en && (next_min == alarm_q);

`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_MIN + 1);
  logic          snz_act_q, snz_act_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;

  always_ff @(posedge MCLK) begin
    if (!RSTN) begin
      snz_act_q <= 1'b0;
      snz_cnt_q <= '0;
    end else begin
      snz_act_q <= snz_act_d;
      snz_cnt_q <= snz_cnt_d;
    end
  end
`endif

  always_comb begin
    presc_d    = presc_q + PW'(1);
    sec_d      = sec_q;
    time_d     = time_q;
    alarm_d    = alarm_q;
    loc_d      = loc_q;
    aloc_d     = aloc_q;
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
    snz_act_d  = snz_act_q;
    snz_cnt_d  = snz_cnt_q;
`endif
    if (tick || mode_q == CLK_SET || mode_d == CLK_SET) presc_d = '0;
    if (tick) begin
      if (min_roll) begin
        sec_d  = '0;
        time_d = next_min;
      end else begin
        sec_d  = sec_q + 6'd1;
      end
    end
    if (mode_q == CLK_SET) begin
      if (mode_pulse) sec_d  = '0;
      if (left_act)   loc_d  = loc_q + 2'd1;
      if (up_act)     time_d = bump_digit(time_q, loc_q);
    end
    if (mode_q == ALM_SET) begin
      if (left_act) aloc_d  = aloc_q + 2'd1;
      if (up_act)   alarm_d = bump_digit(alarm_q, aloc_q);
    end
    if (mode_pulse && mode_d == CLK_SET) loc_d  = '0;
    if (mode_pulse && mode_d == ALM_SET) aloc_d = '0;
    if (ring_q && tick) begin
      ring_cnt_d = ring_cnt_q - RW'(1);
      if (ring_cnt_q == RW'(1)) ring_d = 1'b0;
    end
    if (trigger) begin
      ring_d     = 1'b1;
      ring_cnt_d = RW'(RING_SECONDS);
    end
`ifdef ALARM_SNOOZE_EN
    if (stop_pulse && ring_q) begin
      snz_act_d = 1'b1;
      snz_cnt_d = SW'(SNOOZE_MIN);
    end else if (snz_act_q && min_roll) begin
      if (snz_cnt_q == SW'(1)) begin
        snz_act_d = 1'b0;
        if (mode_q == RUN && alarm_en) begin
          ring_d     = 1'b1;
          ring_cnt_d = RW'(RING_SECONDS);
        end
      end else begin
        snz_cnt_d = snz_cnt_q - SW'(1);
      end
    end
    if (mode_pulse || !alarm_en) snz_act_d = 1'b0;
`endif
    if (mode_pulse || stop_pulse || en_fall) ring_d = 1'b0;
  end

  always_ff @(posedge MCLK) begin
    if (!RSTN) begin
      presc_q    <= '0;
      sec_q      <= '0;
      time_q     <= '0;
      alarm_q    <= '0;
      loc_q      <= '0;
      aloc_q     <= '0;
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      time_q     <= time_d;
      alarm_q    <= alarm_d;
      loc_q      <= loc_d;
      aloc_q     <= aloc_d;
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  bcd_to_seg7 u_seg3 (.bcd_i(disp_src.mu), .seg_o(seg3_d));
  bcd_to_seg7 u_seg2 (.bcd_i(disp_src.mt), .seg_o(seg2_d));
  bcd_to_seg7 u_seg1 (.bcd_i(disp_src.hu), .seg_o(seg1_d));
  bcd_to_seg7 u_seg0 (.bcd_i(disp_src.ht), .seg_o(seg0_d));

  // Output stage: every display-side signal leaves from a flop.
  always_ff @(posedge MCLK) begin
    if (!RSTN) begin
      seg3_q      <= SEG_0;
      seg2_q      <= SEG_0;
      seg1_q      <= SEG_0;
      seg0_q      <= SEG_0;
      clock_set_q <= 1'b0;
      alarm_set_q <= 1'b0;
      ring_out_q  <= 1'b0;
      loc_out_q   <= '0;
      aloc_out_q  <= '0;
    end else begin
      seg3_q      <= seg3_d;
      seg2_q      <= seg2_d;
      seg1_q      <= seg1_d;
      seg0_q      <= seg0_d;
      clock_set_q <= clock_set_d;
      alarm_set_q <= alarm_set_d;
      ring_out_q  <= ring_q;
      loc_out_q   <= loc_q;
      aloc_out_q  <= aloc_q;
    end
  end

  assign DISPLAY_3      = seg3_q;
  assign DISPLAY_2      = seg2_q;
  assign DISPLAY_1      = seg1_q;
  assign DISPLAY_0      = seg0_q;
  assign clock_set      = clock_set_q;
  assign alarm_set      = alarm_set_q;
  assign alarm_ringing  = ring_out_q;
  assign location       = loc_out_q;
  assign alarm_location = aloc_out_q;

endmodule

// File: tb/tb_alarm_clock_core.sv
// Scoreboard bench for alarm_clock_core with a fast prescaler (CLK_HZ = 10).
module tb_alarm_clock_core;

  localparam logic [3:0] B_MODE = 4'b0001;
  localparam logic [3:0] B_LEFT = 4'b0010;
  localparam logic [3:0] B_UP   = 4'b0100;

  logic clk = 1'b0, rstn = 1'b0, alarm_en = 1'b0;
  logic b_mode = 1'b0, b_left = 1'b0, b_up = 1'b0, b_stop = 1'b0;
  logic [6:0] d3, d2, d1, d0;
  logic cs, as_f, ring;
  logic [1:0] loc, aloc;

  alarm_clock_core #(.CLK_HZ(10), .RING_SECONDS(3)) dut (
    .MCLK(clk), .RSTN(rstn), .BTN_MODE(b_mode), .BTN_LEFT(b_left), .BTN_UP(b_up),
    .BTN_STOP(b_stop), .ALARM_EN(alarm_en),
    .DISPLAY_3(d3), .DISPLAY_2(d2), .DISPLAY_1(d1), .DISPLAY_0(d0),
    .clock_set(cs), .alarm_set(as_f), .alarm_ringing(ring),
    .location(loc), .alarm_location(aloc)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [34:0] exp_q[$];
  string       name_q[$];
  logic        chk_stb = 1'b0, done_stb = 1'b0;
  int          n_vec = 0, n_bad = 0;
  int          last_start = 0, t0 = 0;
  logic [34:0] e_cur;
  string       n_cur;
  wire  [34:0] act = {d3, d2, d1, d0, cs, as_f, ring, loc, aloc};

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'b1111111;
    endcase
  endfunction

  // Expected outputs: HH:MM digits, clock_set, alarm_set, ringing, location, alarm_location.
  function automatic logic [34:0] mk(input int ht, input int hu, input int mt, input int mu,
                                     input logic c, input logic a, input logic r,
                                     input logic [1:0] l, input logic [1:0] al);
    return {seg(mu), seg(mt), seg(hu), seg(ht), c, a, r, l, al};
  endfunction

  always @(negedge clk) begin
    if (chk_stb) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL monitor: got %h with no expected entry queued", act);
      end else begin
        e_cur = exp_q.pop_front();
        n_cur = name_q.pop_front();
        if (act !== e_cur) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h (t=%0d)", n_cur, act, e_cur, cycle);
        end
      end
    end
    if (done_stb && exp_q.size() != 0) begin
      n_bad += exp_q.size();
      $display("FAIL leftover: %0d expected entries never checked", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cycle < t) cyc(1);
  endtask

  task automatic check(input string nm, input logic [34:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_stb = 1'b1;
    cyc(1);
    chk_stb = 1'b0;
  endtask

  task automatic press(input logic [3:0] m);
    last_start = cycle;
    {b_stop, b_up, b_left, b_mode} = m;
    cyc(4);
    {b_stop, b_up, b_left, b_mode} = 4'b0000;
    cyc(4);
  endtask

  // Reset, set alarm 00:01 and return to RUN; t0 is the cycle time restarts at 00:00:00.
  task automatic alarm_setup();
    rstn = 1'b0;
    alarm_en = 1'b1;
    cyc(2);
    rstn = 1'b1;
    cyc(1);
    press(B_MODE);
    press(B_MODE);
    t0 = last_start + 3;
    press(B_UP);
    check("alarm_0001_view", mk(0, 0, 0, 1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
    press(B_MODE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cycle);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    cyc(2);
    check("reset", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    rstn = 1'b1;
    cyc(1);

    press(B_MODE);
    check("enter_clk_set", mk(0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0));
    repeat (9) press(B_UP);
    press(B_LEFT);
    repeat (5) press(B_UP);
    press(B_LEFT);
    repeat (3) press(B_UP);
    press(B_LEFT);
    repeat (2) press(B_UP);
    check("set_2359", mk(2, 3, 5, 9, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0));
    press(B_MODE);
    t0 = last_start + 3;
    check("alm_set_view", mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0));
    press(B_MODE);
    check("run_2359", mk(2, 3, 5, 9, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0));
    wait_until(t0 + 620);
    check("rollover_0000", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0));

    press(B_MODE);
    press(B_LEFT);
    for (int i = 1; i <= 6; i++) begin
      press(B_UP);
      check($sformatf("min_tens_%0d", i), mk(0, 0, i % 6, 0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0));
    end
    press(B_LEFT);
    repeat (9) press(B_UP);
    check("hour_units_9", mk(0, 9, 0, 0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0));
    press(B_LEFT);
    press(B_UP);
    check("hour_tens_1", mk(1, 9, 0, 0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0));
    press(B_UP);
    check("hour_tens_2_clamp", mk(2, 3, 0, 0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0));
    press(B_UP);
    check("hour_tens_wrap", mk(0, 3, 0, 0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0));
    press(B_LEFT);
    check("cursor_wrap", mk(0, 3, 0, 0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0));

    alarm_setup();
    wait_until(t0 + 590);
    check("pre_alarm", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    wait_until(t0 + 615);
    check("ringing", mk(0, 0, 0, 1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
    wait_until(t0 + 645);
    check("ring_timeout", mk(0, 0, 0, 1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));

    alarm_setup();
    wait_until(t0 + 608);
    check("ringing_again", mk(0, 0, 0, 1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
    wait_until(t0 + 610);
    b_stop = 1'b1;
    wait_until(t0 + 614);
    check("stop_clears", mk(0, 0, 0, 1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    b_stop = 1'b0;
    cyc(4);

    press(B_MODE);
    check("clk_set_again", mk(0, 0, 0, 1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0));
    press(B_MODE | B_UP);
    check("mode_beats_up", mk(0, 0, 0, 1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
    press(B_MODE);
    check("time_kept", mk(0, 0, 0, 1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));

    press(B_MODE);
    press(B_MODE);
    rstn = 1'b0;
    cyc(1);
    check("reset_in_alm_set", mk(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    rstn = 1'b1;
    cyc(1);
    press(B_MODE);
    press(B_MODE);
    check("alarm_cleared", mk(0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));

    done_stb = 1'b1;
    cyc(1);
    done_stb = 1'b0;
    cyc(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_clock_core.md
Name: alarm_clock_core

Overview:
- Timekeeping and user-setting engine that feeds the 4-digit multiplexed 7-segment display stage.
- Keeps HH:MM:SS (24 h) plus an HH:MM alarm, runs the RUN / CLOCK-SET / ALARM-SET mode FSM and raises alarm ringing.
- Drives all display-stage inputs: four active-low 7-segment digit codes, set flags, cursor locations and the ringing flag.

Parameters:
- CLK_HZ, 100_000_000, MCLK cycles per one-second tick.
- RING_SECONDS, 60, seconds alarm_ringing stays high unless stopped.
- SNOOZE_MIN, 5, snooze delay in minutes (only with ALARM_SNOOZE_EN).

Ports:
- MCLK in 1: system clock; the only clock.
- RSTN in 1: reset, synchronous, active-low.
- BTN_MODE in 1: debounced level; rising edge advances the mode.
- BTN_LEFT in 1: debounced level; rising edge moves the cursor.
- BTN_UP in 1: debounced level; rising edge increments the digit under the cursor.
- BTN_STOP in 1: debounced level; rising edge stops ringing.
- ALARM_EN in 1: switch level; enables the alarm match.
- DISPLAY_3 out 7: minute units, seg code {g..a}, active-low.
- DISPLAY_2 out 7: minute tens.
- DISPLAY_1 out 7: hour units.
- DISPLAY_0 out 7: hour tens.
- clock_set out 1: mode == CLK_SET.
- alarm_set out 1: mode == ALM_SET.
- alarm_ringing out 1: alarm active.
- location out 2: clock cursor; 0 = minute units … 3 = hour tens.
- alarm_location out 2: alarm cursor, same encoding.

Behaviour:
- Reset (RSTN low at MCLK edge):
  - time 00:00:00, alarm 00:00, mode RUN, prescaler 0.
  - All flags 0, both locations 0.
  - DISPLAY_* = 7'b1000000 ('0').
- Button inputs: 2-flop synchronizer, then rising-edge detect giving a 1-cycle pulse. A button held across reset produces no edge after reset.
- Action latency: one cycle from edge pulse to register update. All outputs are registered and reflect the new state on the following cycle.
- Prescaler:
  - Counts 0..CLK_HZ-1; tick at CLK_HZ-1, then wraps.
  - Cleared on entry to CLK_SET and while in CLK_SET.
- Time on tick, in RUN and ALM_SET:
  - sec 59→0 carries to min; min 59→0 carries to hour; hour 23→0.
- Mode FSM, on BTN_MODE edge: RUN→CLK_SET→ALM_SET→RUN.
  - Entering CLK_SET: location = 0, time frozen.
  - Entering ALM_SET: alarm_location = 0.
  - Leaving CLK_SET: seconds forced to 0.
  - Any mode change clears alarm_ringing.
- CLK_SET / ALM_SET editing:
  - BTN_LEFT: cursor = (cursor+1) mod 4.
  - BTN_UP: increment the selected digit of time (CLK_SET) or alarm (ALM_SET) with per-digit wrap:
    - min units 9→0 and min tens 5→0, no carry between them;
    - hour units: 9→0, or 3→0 when hour tens = 2;
    - hour tens 2→0. Incrementing hour tens to 2 while hour units > 3 clamps hour units to 3.
- Display source: alarm digits in ALM_SET, time digits otherwise. BCD→seg: 0..9 standard; invalid codes → 7'b1111111.
- Alarm trigger:
  - Condition: tick causes min rollover, mode RUN, ALARM_EN = 1, and the new HH:MM equals the alarm.
  - Action: alarm_ringing = 1, ring counter = RING_SECONDS.
  - Ring counter decrements per tick; reaching 0 clears ringing.
  - BTN_STOP edge clears ringing the next cycle.
  - ALARM_EN falling clears ringing.
- Simultaneous edges in one cycle: priority MODE > LEFT > UP; lower-priority edges are dropped. STOP is independent of the others.
- In ALM_SET, a tick and a BTN_UP in the same cycle both take effect (different registers).

Optional Feature:
- Macro ALARM_SNOOZE_EN.
- Defined:
  - BTN_STOP while ringing clears ringing and loads a snooze minute counter with SNOOZE_MIN.
  - The counter decrements on each minute rollover; at 0 ringing restarts (RUN, ALARM_EN = 1).
  - A mode change or ALARM_EN = 0 cancels snooze.
- Undefined: BTN_STOP only stops ringing; no snooze logic is synthesized.

Decomposition:
- Package alarm_clock_pkg:
  - mode encoding (RUN = 0, CLK_SET = 1, ALM_SET = 2);
  - digit index constants (MIN_U = 0 … HOUR_T = 3);
  - SEG_BLANK = 7'b1111111 and the 0..9 seg constants.
- Sub-module bcd_to_seg7: combinational 4-bit→7-bit, instanced 4×; outputs registered in the parent.

Test Plan:
- Reset: RSTN low 2 cycles → DISPLAY_0..3 = 7'b1000000; clock_set, alarm_set, alarm_ringing = 0; location = 0.
- CLK_HZ = 10. Set 23:59 (MODE, UP/LEFT sequence, MODE ×2 back to RUN), then 600 cycles → display 00:00, hour rollover correct.
- CLK_SET, location 1, UP ×6 → min tens 0,1,…,5,0. Hour units 9, then hour tens to 2 → hour units 3.
- Alarm 00:01, ALARM_EN = 1, RUN from 00:00:00, CLK_HZ = 10, RING_SECONDS = 3:
  - after 60 ticks → alarm_ringing = 1;
  - clears 3 ticks later;
  - repeat with BTN_STOP → clears next cycle.
- BTN_MODE and BTN_UP same cycle in CLK_SET → mode = ALM_SET, time digits unchanged.
- RSTN low mid-ALM_SET with ringing → next cycle mode RUN, all flags 0, time and alarm 00:00.
